// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// fills the IF/ID register, with stall/flush/redirect and a clean stop at image end.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] MEM_DEPTH = 32'd128
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state;

  logic [31:0] pc_inc;
  logic        redir_ok;

  assign pc_inc   = pc + 32'd1;
  assign redir_ok = redirect_pc < MEM_DEPTH;
  // Memory is idle once past the image so no out-of-range address is ever driven.
  assign mem_addr = (state == HALT) ? 32'd0 : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= BOOT;
      if_id_instr <= 32'd0;
      if_id_npc   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          // One bubble after reset; a redirect here still decides RUN vs HALT.
          if (redirect) begin
            pc    <= redirect_pc;
            state <= redir_ok ? RUN : HALT;
          end else begin
            state <= (pc < MEM_DEPTH) ? RUN : HALT;
          end
        end
        RUN: begin
          if (redirect) begin
            pc          <= redirect_pc;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'd0;
            if (!redir_ok) state <= HALT;
          end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= 32'd0;
          end else if (!stall) begin
            if_id_instr <= mem_data;
            if_id_npc   <= pc_inc;
            if_id_valid <= 1'b1;
            pc          <= pc_inc;
            if (pc == MEM_DEPTH - 32'd1) state <= HALT;
          end
        end
        HALT: begin
          if (redirect) begin
            // Only an in-range target restarts fetch; the PC stays parked otherwise.
            if_id_valid <= 1'b0;
            if_id_instr <= 32'd0;
            if (redir_ok) begin
              pc    <= redirect_pc;
              state <= RUN;
            end
          end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= 32'd0;
          end else if (!stall) begin
            if_id_valid <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
